// File: rtl/telemetry_frame_scheduler.sv
// Periodic telemetry framer: snapshots the channel counters on a report tick and
// streams SYNC, seq, counts, checksum through the shared UART write/busy handshake.
module telemetry_frame_scheduler #(
  parameter int         NUM_CH    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                tick,
  input  logic [8*NUM_CH-1:0] cnt_in,
  output logic                cnt_clr,
  input  logic                uart_busy,
  output logic                uart_wr,
  output logic [7:0]          uart_dat,
  output logic                frame_active,
  output logic [7:0]          seq_num,
  output logic [7:0]          overrun_cnt
);
  localparam int               IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH + 2);

  typedef enum logic [2:0] {IDLE, SNAP, LOAD, STROBE, WAIT_HI, WAIT_LO} state_e;

  state_e                 state_q;
  logic [NUM_CH-1:0][7:0] snap_q;
  logic [IDX_W-1:0]       idx_q;
  logic [7:0]             chk_q, seq_q, ovr_q, dat_q;
  logic                   clr_q, wr_q, act_q;
  logic [7:0]             byte_d, chk_d;

  // Frame byte at the current index; the last index falls through to the checksum.
  always_comb begin
    byte_d = chk_q;
    chk_d  = chk_q;
    if (idx_q == '0)            byte_d = SYNC_BYTE;
    else if (idx_q == IDX_W'(1)) byte_d = seq_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == IDX_W'(k + 2)) begin
        byte_d = snap_q[k];
        chk_d  = chk_q + snap_q[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
      seq_q   <= '0;
      ovr_q   <= '0;
      dat_q   <= '0;
      clr_q   <= 1'b0;
      wr_q    <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      wr_q  <= 1'b0;
      // Any tick outside IDLE, including the frame's final cycle, is dropped.
      if (tick && state_q != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
      case (state_q)
        IDLE: if (tick) begin
          state_q <= SNAP;
          clr_q   <= 1'b1;
          act_q   <= 1'b1;
        end
        SNAP: begin
          snap_q  <= cnt_in;
          idx_q   <= '0;
          chk_q   <= seq_q;
          state_q <= LOAD;
        end
        LOAD: begin
          dat_q   <= byte_d;
          chk_q   <= chk_d;
          state_q <= STROBE;
        end
        STROBE: if (!uart_busy) begin
          wr_q    <= 1'b1;
          state_q <= WAIT_HI;
        end
        WAIT_HI: if (uart_busy) state_q <= WAIT_LO;
        WAIT_LO: if (!uart_busy) begin
          if (idx_q == LAST_IDX) begin
            seq_q   <= seq_q + 8'd1;
            act_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt_clr      = clr_q;
  assign uart_wr      = wr_q;
  assign uart_dat     = dat_q;
  assign frame_active = act_q;
  assign seq_num      = seq_q;
  assign overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_telemetry_frame_scheduler.sv
// Bench for telemetry_frame_scheduler: frame-level scoreboard plus directed scenarios.
`timescale 1ns/1ps
module tb_telemetry_frame_scheduler;
  localparam int NUM_CH = 4;
  localparam int FLEN   = NUM_CH + 3;

  logic                CLK = 1'b0, RST_N = 1'b0, tick = 1'b0, uart_busy = 1'b0;
  logic [8*NUM_CH-1:0] cnt_in = '0;
  logic                cnt_clr, uart_wr, frame_active;
  logic [7:0]          uart_dat, seq_num, overrun_cnt;

  telemetry_frame_scheduler #(.NUM_CH(NUM_CH), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .RST_N(RST_N), .tick(tick), .cnt_in(cnt_in), .cnt_clr(cnt_clr),
    .uart_busy(uart_busy), .uart_wr(uart_wr), .uart_dat(uart_dat),
    .frame_active(frame_active), .seq_num(seq_num), .overrun_cnt(overrun_cnt)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART stand-in: busy rises the cycle after a write and stays up busy_len cycles.
  bit ext_busy = 1'b0;
  int busy_len = 10;
  initial begin : uart_model
    int   bcnt;
    logic w;
    bcnt = 0;
    forever begin
      @(negedge CLK); w = uart_wr;
      @(posedge CLK); #1;
      if (w === 1'b1) bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
      uart_busy = ext_busy || (bcnt > 0);
    end
  end

  // Frame-level model: accepted ticks produce a byte list from the counters seen
  // in the clear cycle; a frame ends when the UART goes idle after its last byte.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int clr_count = 0, wr_count = 0;
  initial begin : scoreboard
    bit         m_active, m_clr, m_armed, m_seen, m_first, busy_prev, end_now, start;
    logic [7:0] m_seq, m_ovr, sum;
    int         m_sent, cyc, tick_cyc;
    m_active = 0; m_clr = 0; m_armed = 0; m_seen = 0; m_first = 0; busy_prev = 0;
    m_seq = 0; m_ovr = 0; m_sent = 0; cyc = 0; tick_cyc = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST_N) begin
        chk("reset_outputs", {cnt_clr, uart_wr, uart_dat, frame_active, seq_num, overrun_cnt}, 64'd0);
        m_active = 0; m_clr = 0; m_armed = 0; m_seen = 0; m_first = 0;
        m_seq = 0; m_ovr = 0; m_sent = 0;
        exp_q.delete();
      end else begin
        chk("cnt_clr", cnt_clr, m_clr);
        chk("frame_active", frame_active, m_active);
        chk("seq_num", seq_num, m_seq);
        chk("overrun_cnt", overrun_cnt, m_ovr);
        chk("clr_wr_overlap", cnt_clr & uart_wr, 0);
        if (m_clr) begin
          clr_count++;
          sum = m_seq;
          exp_q.push_back(8'hA5);
          exp_q.push_back(m_seq);
          for (int k = 0; k < NUM_CH; k++) begin
            exp_q.push_back(cnt_in[8*k +: 8]);
            sum = sum + cnt_in[8*k +: 8];
          end
          exp_q.push_back(sum);
        end
        if (uart_wr) begin
          wr_count++;
          rx_q.push_back(uart_dat);
          chk("wr_needs_idle_uart", busy_prev, 0);
          if (m_first) begin
            chk("first_wr_latency_ge3", (cyc - tick_cyc) >= 3, 1);
            m_first = 0;
          end
          chk("wr_has_expected_byte", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("uart_dat", uart_dat, exp_q.pop_front());
          m_sent++;
        end
        end_now = 0;
        if (m_armed) begin
          if (uart_busy) m_seen = 1;
          else if (m_seen) end_now = 1;
        end
        if (uart_wr && m_sent == FLEN) begin m_armed = 1; m_seen = 0; end
        start = tick && !m_active;
        if (tick && m_active && m_ovr != 8'hFF) m_ovr++;
        if (end_now) begin m_active = 0; m_armed = 0; m_seq++; end
        m_clr = start;
        if (start) begin m_active = 1; m_sent = 0; m_first = 1; tick_cyc = cyc; end
      end
      busy_prev = uart_busy;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_tick(input int extra);
    @(posedge CLK); #1 tick = 1'b1;
    repeat (extra) begin @(posedge CLK); #1; end
    @(posedge CLK); #1 tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (frame_active === 1'b1 && n < 4000) begin @(negedge CLK); n++; end
    chk("frame_done_in_budget", frame_active, 0);
  endtask

  task automatic check_frame(input string name, input int base, input logic [7:0] e [FLEN]);
    chk($sformatf("%s_len", name), rx_q.size() - base, FLEN);
    for (int i = 0; i < FLEN; i++)
      if (base + i < rx_q.size()) chk($sformatf("%s_b%0d", name, i), rx_q[base + i], e[i]);
  endtask

  initial begin : stim
    logic [7:0] exp1 [FLEN];
    logic [7:0] exp2 [FLEN];
    int base, w0, c0, n;
    exp1 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    exp2 = '{8'hA5, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("por_seq", seq_num, 0);
    chk("por_active", frame_active, 0);
    #2 RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    // Basic frame with known counts.
    cnt_in = {8'h04, 8'h03, 8'h02, 8'h01};
    base = rx_q.size(); c0 = clr_count;
    send_tick(0);
    wait_idle();
    check_frame("frame1", base, exp1);
    chk("frame1_clr_pulses", clr_count - c0, 1);
    chk("frame1_seq_after", seq_num, 8'h01);
    chk("frame1_inactive", frame_active, 0);

    // Overruns after a fresh reset.
    @(negedge CLK); #1 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;
    send_tick(0);
    repeat (3) begin
      repeat (4) @(posedge CLK);
      #1 tick = 1'b1;
      @(posedge CLK); #1 tick = 1'b0;
    end
    wait_idle();
    chk("overrun_three", overrun_cnt, 8'd3);
    base = rx_q.size();
    send_tick(0);
    wait_idle();
    chk("second_frame_seq", rx_q[base + 1], 8'h01);
    chk("overrun_held", overrun_cnt, 8'd3);

    // Saturated counts with seq 3; counters change after the snapshot.
    cnt_in = '0;
    send_tick(0);
    wait_idle();
    cnt_in = '1;
    base = rx_q.size();
    send_tick(0);
    @(posedge CLK); #1 cnt_in = 32'h12345678;
    wait_idle();
    check_frame("frame_ff", base, exp2);

    // UART busy held externally at frame start.
    ext_busy = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    send_tick(0);
    w0 = wr_count;
    repeat (8) @(posedge CLK);
    chk("no_wr_while_busy", wr_count - w0, 0);
    #1 ext_busy = 1'b0;
    n = 0;
    @(negedge CLK);
    while (uart_busy && n < 50) begin @(negedge CLK); n++; end
    chk("busy_released", uart_busy, 0);
    @(negedge CLK);
    chk("wr_cycle_after_busy_drop", uart_wr, 1);
    wait_idle();

    // Reset during byte 3.
    w0 = wr_count;
    send_tick(0);
    n = 0;
    while (wr_count < w0 + 4 && n < 2000) begin @(negedge CLK); n++; end
    chk("byte3_reached", wr_count >= w0 + 4, 1);
    @(posedge CLK); #3 RST_N = 1'b0;
    #1 chk("async_reset_outputs", {cnt_clr, uart_wr, uart_dat, frame_active, seq_num, overrun_cnt}, 64'd0);
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;
    base = rx_q.size();
    send_tick(0);
    wait_idle();
    chk("post_reset_frame_seq", rx_q[base + 1], 8'h00);
    chk("post_reset_seq_after", seq_num, 8'h01);

    // Sequence wrap and overrun saturation.
    busy_len = 3;
    for (int f = 1; f <= 256; f++) begin
      base = rx_q.size();
      send_tick(f <= 150 ? 2 : 0);
      wait_idle();
      if (f == 127) chk("overrun_254", overrun_cnt, 8'hFE);
      if (f == 255) chk("seq_wrapped_to_0", seq_num, 8'h00);
      if (f == 256) chk("wrap_frame_seq_byte", rx_q[base + 1], 8'h00);
    end
    chk("seq_after_256", seq_num, 8'h01);
    chk("overrun_saturated", overrun_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
